// File: rtl/bram_read_arbiter.sv
// Shares one feature-map BRAM read port among NUM_REQ row-FIFO fillers and routes returning data by tag.
// Define ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration; otherwise round robin.
module bram_read_arbiter #(
  parameter int unsigned NUM_REQ = 9,
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned RD_LAT  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        fifo_full,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      mem_en,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [NUM_REQ-1:0]        fifo_wr,
  output logic [DATA_W-1:0]         fifo_wdata,
  output logic                      busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned LAST  = RD_LAT - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 arb_run;
  logic [NUM_REQ-1:0]   inflight;
  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   win_mask;
  logic [NUM_REQ-1:0]   done_mask;
  logic                 win_vld;
  logic [IDX_W-1:0]     win_idx;
  logic [ADDR_W-1:0]    win_addr;
  logic [RD_LAT-1:0]    tag_vld;
  logic [IDX_W-1:0]     tag_idx [RD_LAT];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // DRAIN lingers until the last tagged read has been written into its FIFO.
  always_comb begin
    state_nxt = state;
    arb_run   = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        arb_run = 1'b1;
        if (!enable) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (enable) begin
          state_nxt = RUN;
        end else if (inflight == '0) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    eligible = req & ~fifo_full & ~inflight;
  end

`ifdef ARB_FIXED_PRIORITY_EN
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    if (arb_run) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (eligible[i]) begin
          win_vld = 1'b1;
          win_idx = IDX_W'(i);
        end
      end
    end
  end
`else
  logic [IDX_W-1:0] rr_ptr;

  // Scan from farthest to nearest after rr_ptr so the nearest eligible index is written last.
  always_comb begin
    logic [IDX_W:0] cand;
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    if (arb_run) begin
      for (int k = NUM_REQ; k > 0; k--) begin
        cand = (IDX_W+1)'(rr_ptr) + (IDX_W+1)'(k);
        if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
        if (eligible[cand[IDX_W-1:0]]) begin
          win_vld = 1'b1;
          win_idx = cand[IDX_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= IDX_W'(NUM_REQ - 1);
    end else if (win_vld) begin
      rr_ptr <= win_idx;
    end
  end
`endif

  always_comb begin
    win_mask  = '0;
    done_mask = '0;
    win_addr  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_vld && (win_idx == IDX_W'(i))) begin
        win_mask[i] = 1'b1;
        win_addr    = req_addr[i*ADDR_W +: ADDR_W];
      end
      if (tag_vld[LAST] && (tag_idx[LAST] == IDX_W'(i))) begin
        done_mask[i] = 1'b1;
      end
    end
  end

  // Tag shift register tracks which requester owns each read in the BRAM pipe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_vld <= '0;
      for (int s = 0; s < RD_LAT; s++) tag_idx[s] <= '0;
    end else begin
      tag_vld[0] <= win_vld;
      tag_idx[0] <= win_idx;
      for (int s = 1; s < RD_LAT; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_idx[s] <= tag_idx[s-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant      <= '0;
      mem_en     <= 1'b0;
      mem_addr   <= '0;
      fifo_wr    <= '0;
      fifo_wdata <= '0;
      busy       <= 1'b0;
      inflight   <= '0;
    end else begin
      grant    <= win_mask;
      mem_en   <= win_vld;
      if (win_vld) mem_addr <= win_addr;
      fifo_wr  <= done_mask;
      if (tag_vld[LAST]) fifo_wdata <= mem_rdata;
      busy     <= (state_nxt != IDLE);
      inflight <= (inflight & ~done_mask) | win_mask;
    end
  end

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Scoreboard bench for bram_read_arbiter: directed and random requester traffic checked per cycle
// against a transaction-level model. Also valid with +define+ARB_FIXED_PRIORITY_EN.
module tb_bram_read_arbiter;

  localparam int unsigned NUM_REQ = 9;
  localparam int unsigned ADDR_W  = 14;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned RD_LAT  = 2;

  localparam int M_HOLD  = 0;
  localparam int M_ALL   = 1;
  localparam int M_FULL2 = 2;
  localparam int M_RAND  = 3;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_DRAIN = 2;

  logic                      clk       = 1'b0;
  logic                      reset     = 1'b0;
  logic                      enable    = 1'b0;
  logic [NUM_REQ-1:0]        req       = '0;
  logic [NUM_REQ*ADDR_W-1:0] req_addr  = '0;
  logic [NUM_REQ-1:0]        fifo_full = '0;
  logic [DATA_W-1:0]         mem_rdata;
  logic [NUM_REQ-1:0]        grant;
  logic                      mem_en;
  logic [ADDR_W-1:0]         mem_addr;
  logic [NUM_REQ-1:0]        fifo_wr;
  logic [DATA_W-1:0]         fifo_wdata;
  logic                      busy;

  bram_read_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .req(req), .req_addr(req_addr),
    .fifo_full(fifo_full), .mem_rdata(mem_rdata), .grant(grant), .mem_en(mem_en),
    .mem_addr(mem_addr), .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] bram_data(input logic [ADDR_W-1:0] a);
    logic [31:0] x;
    x = 32'(a) * 32'd40503 + 32'h1357;
    return DATA_W'(x ^ (x >> 16));
  endfunction

  // BRAM contents are a hash of the address; one address register plus the arbiter's capture stage make RD_LAT=2.
  logic [ADDR_W-1:0] bram_addr_q = '0;
  always @(posedge clk) bram_addr_q <= mem_addr;
  assign mem_rdata = bram_data(bram_addr_q);

  typedef struct {
    logic [NUM_REQ-1:0] grant;
    logic               mem_en;
    logic [ADDR_W-1:0]  mem_addr;
    logic [NUM_REQ-1:0] fifo_wr;
    logic [DATA_W-1:0]  fifo_wdata;
    logic               busy;
  } exp_t;

  typedef struct {
    int                due;
    int                idx;
    logic [DATA_W-1:0] data;
  } pend_t;

  int checks = 0;
  int errors = 0;

  exp_t  exp_q[$];
  pend_t pend_q[$];

  int                m_state;
  int                m_inflight[NUM_REQ];
  int                m_last;
  int                m_cyc;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;

  bit                r_req[NUM_REQ];
  bit                r_full[NUM_REQ];
  logic [ADDR_W-1:0] r_addr[NUM_REQ];
  bit                full2 = 1'b0;

  bit   mon_en = 1'b0;
  bit   log_en = 1'b0;
  int   mon_cyc = 0;
  int   gl_idx[$];
  int   gl_cyc[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_grant"},      32'(grant),      32'd0);
    chk({tag, "_mem_en"},     32'(mem_en),     32'd0);
    chk({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
    chk({tag, "_fifo_wr"},    32'(fifo_wr),    32'd0);
    chk({tag, "_fifo_wdata"}, 32'(fifo_wdata), 32'd0);
    chk({tag, "_busy"},       32'(busy),       32'd0);
  endtask

  task automatic model_reset();
    m_state = S_IDLE;
    m_last  = NUM_REQ - 1;
    m_cyc   = 0;
    m_addr  = '0;
    m_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) m_inflight[i] = 0;
    pend_q.delete();
    exp_q.delete();
  endtask

  // Predicts every output for the cycle after the coming clock edge from the inputs now applied.
  task automatic model_step(input logic en);
    exp_t  e;
    pend_t p;
    int    win;
    int    cand;
    int    n_fly;
    m_cyc++;
    e.grant      = '0;
    e.mem_en     = 1'b0;
    e.mem_addr   = m_addr;
    e.fifo_wr    = '0;
    e.fifo_wdata = m_wdata;
    e.busy       = 1'b0;
    n_fly = 0;
    for (int i = 0; i < NUM_REQ; i++) n_fly += m_inflight[i];
    win = -1;
    if (m_state == S_RUN) begin
`ifdef ARB_FIXED_PRIORITY_EN
      for (int i = 0; i < NUM_REQ; i++)
        if (win < 0 && r_req[i] && !r_full[i] && m_inflight[i] == 0) win = i;
`else
      for (int k = 1; k <= NUM_REQ; k++) begin
        cand = (m_last + k) % int'(NUM_REQ);
        if (win < 0 && r_req[cand] && !r_full[cand] && m_inflight[cand] == 0) win = cand;
      end
`endif
    end
    if (pend_q.size() > 0 && pend_q[0].due == m_cyc) begin
      p = pend_q.pop_front();
      e.fifo_wr[p.idx] = 1'b1;
      e.fifo_wdata     = p.data;
      m_wdata          = p.data;
      m_inflight[p.idx] = 0;
    end
    if (win >= 0) begin
      e.grant[win] = 1'b1;
      e.mem_en     = 1'b1;
      e.mem_addr   = r_addr[win];
      m_addr       = r_addr[win];
      m_inflight[win] = 1;
      m_last       = win;
      p.due  = m_cyc + RD_LAT;
      p.idx  = win;
      p.data = bram_data(r_addr[win]);
      pend_q.push_back(p);
    end
    case (m_state)
      S_IDLE:  if (en) m_state = S_RUN;
      S_RUN:   if (!en) m_state = S_DRAIN;
      default: begin
        if (en) m_state = S_RUN;
        else if (n_fly == 0) m_state = S_IDLE;
      end
    endcase
    e.busy = (m_state != S_IDLE);
    exp_q.push_back(e);
  endtask

  // Requester agents react to the grant seen this cycle, then the new inputs feed the model.
  task automatic drive_cycle(input int mode, input logic en);
    logic [NUM_REQ-1:0] g;
    g = grant;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (g[i]) begin
        r_addr[i] = ADDR_W'($urandom);
        if (mode == M_HOLD) r_req[i] = 1'b0;
        else if (mode != M_ALL) r_req[i] = ($urandom_range(0, 1) == 1);
      end
      if (mode == M_ALL) r_req[i] = 1'b1;
      if (mode == M_RAND || mode == M_FULL2) begin
        if (!r_req[i] && $urandom_range(0, 2) == 0) begin
          r_req[i]  = 1'b1;
          r_addr[i] = ADDR_W'($urandom);
        end
        r_full[i] = ($urandom_range(0, 3) == 0);
      end else begin
        r_full[i] = 1'b0;
      end
    end
    if (mode == M_FULL2) begin
      r_req[2]  = 1'b1;
      r_full[2] = full2;
    end
    enable = en;
    for (int i = 0; i < NUM_REQ; i++) begin
      req[i]       = r_req[i];
      fifo_full[i] = r_full[i];
      req_addr[i*ADDR_W +: ADDR_W] = r_addr[i];
    end
    model_step(en);
    mon_en = 1'b1;
  endtask

  task automatic step(input int mode, input logic en, input int n);
    repeat (n) begin
      @(negedge clk);
      drive_cycle(mode, en);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2;
    mon_en = 1'b0;
    reset  = 1'b0;
    #1;
    check_zero("reset_async");
    enable    = 1'b0;
    req       = '0;
    fifo_full = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      r_req[i]  = 1'b0;
      r_full[i] = 1'b0;
    end
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    mon_cyc++;
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        chk("exp_queue_nonempty", 32'd0, 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("grant",      32'(grant),      32'(mon_e.grant));
        chk("mem_en",     32'(mem_en),     32'(mon_e.mem_en));
        chk("mem_addr",   32'(mem_addr),   32'(mon_e.mem_addr));
        chk("fifo_wr",    32'(fifo_wr),    32'(mon_e.fifo_wr));
        chk("fifo_wdata", 32'(fifo_wdata), 32'(mon_e.fifo_wdata));
        chk("busy",       32'(busy),       32'(mon_e.busy));
      end
    end
    if (log_en) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) begin
          gl_idx.push_back(i);
          gl_cyc.push_back(mon_cyc);
        end
      end
    end
  end

  initial begin
    int n8;
    for (int i = 0; i < NUM_REQ; i++) begin
      r_req[i]  = 1'b0;
      r_full[i] = 1'b0;
      r_addr[i] = '0;
    end
    model_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset_init");
    reset = 1'b1;

    // Lone requester 3 at 0x0105.
    r_req[3]  = 1'b1;
    r_addr[3] = 14'h0105;
    step(M_HOLD, 1'b1, 10);

    // Everyone requesting continuously, then enable drops with reads in flight.
    apply_reset();
    log_en = 1'b1;
    step(M_ALL, 1'b1, 14);
    step(M_ALL, 1'b0, 8);
    log_en = 1'b0;
    chk("grant_log_len", 32'(gl_idx.size() >= 10), 32'd1);
`ifndef ARB_FIXED_PRIORITY_EN
    for (int k = 0; k < 10 && k < gl_idx.size(); k++) begin
      chk("rr_order", 32'(gl_idx[k]), 32'(k % NUM_REQ));
      chk("rr_back_to_back", 32'(gl_cyc[k] - gl_cyc[0]), 32'(k));
    end
`else
    n8 = 0;
    for (int k = 0; k < gl_idx.size(); k++) if (gl_idx[k] == NUM_REQ - 1) n8++;
    for (int k = 0; k < 6 && k < gl_idx.size(); k++)
      chk("fp_order", 32'(gl_idx[k]), 32'(k % (RD_LAT + 1)));
    chk("fp_last_starved", 32'(n8), 32'd0);
`endif

    // Requester 2 blocked by its full FIFO, then released.
    apply_reset();
    step(M_RAND, 1'b1, 6);
    full2 = 1'b1;
    step(M_FULL2, 1'b1, 15);
    full2 = 1'b0;
    step(M_FULL2, 1'b1, 15);

    // Random traffic with enable glitches, a reset with reads in flight, then more traffic.
    repeat (400) begin
      @(negedge clk);
      drive_cycle(M_RAND, $urandom_range(0, 15) != 0);
    end
    apply_reset();
    repeat (300) begin
      @(negedge clk);
      drive_cycle(M_RAND, $urandom_range(0, 15) != 0);
    end
    step(M_HOLD, 1'b0, 12);

    @(posedge clk);
    #2;
    mon_en = 1'b0;
    chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_read_arbiter.md
BRAM_READ_ARBITER -- requirements
Module: bram_read_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 9, number of FIFO-fill requesters (one per systolic row FIFO).
REQ-002 Parameter ADDR_W, default 14, feature-map BRAM address width.
REQ-003 Parameter DATA_W, default 16, BRAM read data width.
REQ-004 Parameter RD_LAT, default 2, BRAM read latency in cycles (1..4).
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 enable  input  1  run/stop for arbitration.
REQ-008 req  input  NUM_REQ  per-requester read request, held until granted.
REQ-009 req_addr  input  NUM_REQ*ADDR_W  flattened addresses; requester i at bits [i*ADDR_W +: ADDR_W].
REQ-010 fifo_full  input  NUM_REQ  per-destination FIFO full flag.
REQ-011 mem_rdata  input  DATA_W  BRAM read data.
REQ-012 grant  output  NUM_REQ  registered one-hot grant pulse.
REQ-013 mem_en  output  1  registered BRAM read enable.
REQ-014 mem_addr  output  ADDR_W  registered BRAM read address.
REQ-015 fifo_wr  output  NUM_REQ  one-hot FIFO write strobe.
REQ-016 fifo_wdata  output  DATA_W  FIFO write data, valid with fifo_wr.
REQ-017 busy  output  1  high in RUN or DRAIN.

Function
REQ-018 FSM states are IDLE, RUN and DRAIN.
REQ-019 IDLE->RUN when enable=1; RUN->DRAIN when enable=0; DRAIN->IDLE when no read is in flight; DRAIN->RUN when enable=1.
REQ-020 Eligibility for requester i is req[i]=1, fifo_full[i]=0 and no read in flight for i; at most one outstanding read per requester.
REQ-021 Arbitration occurs only in RUN, selecting at most one eligible requester per cycle.
REQ-022 On winner i at edge T: grant=one-hot(i), mem_en=1, mem_addr=req_addr[i], all registered and visible during cycle T+1; otherwise grant=0 and mem_en=0, with mem_addr holding its last value.
REQ-023 Requester i drops or updates req[i]/req_addr[i] after seeing grant[i]; the arbiter ignores requester i while its read is in flight, so a stale req is never double-granted.
REQ-024 A tag pipeline of depth RD_LAT carries (valid, index) alongside each read.
REQ-025 fifo_wr[idx]=1 and fifo_wdata=mem_rdata exactly RD_LAT cycles after the mem_en cycle; the in-flight bit for idx clears that same cycle.
REQ-026 fifo_full is checked only at grant; a full flag rising after grant does not cancel the write, so FIFOs reserve RD_LAT+1 slack.
REQ-027 fifo_wr is zero whenever no tag is valid, and fifo_wdata holds its last value.
REQ-028 Back-to-back grants to different requesters on consecutive cycles are allowed, giving a full-throughput port.
REQ-029 No requesters eligible means no grant; the round-robin pointer is unchanged.

Reset
REQ-030 On reset low, asynchronously: state=IDLE, grant=0, mem_en=0, mem_addr=0, fifo_wr=0, fifo_wdata=0, busy=0, all in-flight and tag bits=0, RR pointer=NUM_REQ-1.
REQ-031 Reset during operation discards in-flight reads; no fifo_wr issues for them after release.

Configuration
REQ-032 Macro ARB_FIXED_PRIORITY_EN selects the arbitration policy at compile time.
REQ-033 With the macro defined: fixed priority, lowest eligible index wins.
REQ-034 Without the macro: round robin, where the winner is the first eligible index after the last winner, wrapping NUM_REQ-1->0, and the pointer updates only on grant.

Verification
REQ-035 Single requester: req[3]=1, addr=0x0105, RD_LAT=2 -> grant[3] and mem_addr=0x0105 one cycle after arbitration; fifo_wr[3] with mem_rdata two cycles after mem_en.
REQ-036 All 9 requesting continuously, round robin -> grants 0,1,...,8,0 over ten consecutive cycles, one per cycle, no repeats until wrap.
REQ-037 Same stimulus with ARB_FIXED_PRIORITY_EN -> requester 0 re-granted as soon as its in-flight bit clears; requester 8 is granted only when 0..7 are ineligible.
REQ-038 fifo_full[2]=1 while req[2]=1 -> no grant[2]; after fifo_full[2]=0, grant[2] occurs within NUM_REQ cycles.
REQ-039 enable dropped with 2 reads in flight -> no new grants; both fifo_wr complete; busy falls the cycle after the last write.
REQ-040 reset asserted with reads in flight -> all outputs 0 immediately; no fifo_wr after release.
